conv_mac_scheduler: RTL and testbench

Sequencer that computes a valid-mode 2-D convolution plus ReLU by time-sharing one external pipelined floating-point multiplier and one external floating-point adder, instead of instantiating a multiply/add pair per kernel tap per output pixel. It reads the image and kernel from external synchronous-read buffers by address. It streams each finished output pixel out over a valid/ready handshake. It sits between the layer's image/kernel buffers and the next super-resolution stage.

---
 rtl/conv_mac_scheduler.sv | 111 +++++++++++
 tb/tb_conv_mac_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_scheduler.sv
// conv_mac_scheduler: valid-mode KxK convolution + ReLU sequenced over one shared FP multiplier and adder
module conv_mac_scheduler #(
  parameter int IMG_W = 5,
  parameter int IMG_H = 5,
  parameter int K = 3,
  parameter int WL = 32,
  localparam int OW = IMG_W - K + 1,
  localparam int OH = IMG_H - K + 1,
  localparam int IAW = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1,
  localparam int KAW = (K * K > 1) ? $clog2(K * K) : 1,
  localparam int RW = (OH > 1) ? $clog2(OH) : 1,
  localparam int CW = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rd_en,
  output logic [IAW-1:0] img_addr,
  output logic [KAW-1:0] ker_addr,
  input  logic [WL-1:0]  img_rdata,
  input  logic [WL-1:0]  ker_rdata,
  output logic [WL-1:0]  mul_a,
  output logic [WL-1:0]  mul_b,
  output logic           mul_valid,
  input  logic           mul_res_valid,
  input  logic [WL-1:0]  mul_res,
  output logic [WL-1:0]  add_a,
  output logic [WL-1:0]  add_b,
  output logic           add_valid,
  input  logic           add_res_valid,
  input  logic [WL-1:0]  add_res,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [WL-1:0]  out_data,
  output logic [RW-1:0]  out_row,
  output logic [CW-1:0]  out_col
);
  typedef enum logic [2:0] {IDLE, FETCH, MUL, ADD, OUT} state_t;
  state_t state, state_n;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [KAW-1:0] t;
  logic [WL-1:0] acc, prod;
  logic fresh, last_t, last_c, last_px, mul_ack, add_ack;
  assign last_t = t == KAW'(K * K - 1);
  assign last_c = c == CW'(OW - 1);
  assign last_px = last_c && r == RW'(OH - 1);
  // fresh marks the first cycle of a state, so each unit is issued exactly once per tap
  assign mul_ack = state == MUL && !fresh && mul_res_valid;
  assign add_ack = state == ADD && !fresh && add_res_valid;
  assign busy = state != IDLE;
  assign rd_en = state == FETCH;
  assign img_addr = rd_en ? IAW'((32'(r) + 32'(t) / K) * IMG_W + 32'(c) + 32'(t) % K) : '0;
  assign ker_addr = rd_en ? t : '0;
  assign mul_valid = state == MUL && fresh;
  assign mul_a = mul_valid ? ker_rdata : '0;
  assign mul_b = mul_valid ? img_rdata : '0;
  assign add_valid = state == ADD && fresh;
  assign add_a = add_valid ? prod : '0;
  assign add_b = add_valid ? acc : '0;
  assign out_valid = state == OUT;
  assign out_data = (out_valid && !acc[WL-1]) ? acc : '0;
  assign out_row = out_valid ? r : '0;
  assign out_col = out_valid ? c : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (start && !done) ? FETCH : IDLE;
      FETCH:   state_n = MUL;
      MUL:     state_n = mul_ack ? ADD : MUL;
      ADD:     state_n = add_ack ? (last_t ? OUT : FETCH) : ADD;
      OUT:     state_n = out_ready ? (last_px ? IDLE : FETCH) : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      fresh <= 1'b0;
      done <= 1'b0;
      r <= '0;
      c <= '0;
      t <= '0;
      acc <= '0;
      prod <= '0;
    end else begin
      state <= state_n;
      fresh <= state_n != state;
      done <= state == OUT && out_ready && last_px;
      if (state == IDLE && start && !done) begin
        r <= '0;
        c <= '0;
        t <= '0;
        acc <= '0;
      end
      if (mul_ack) prod <= mul_res;
      if (add_ack) begin
        acc <= add_res;
        t <= last_t ? t : t + 1'b1;
      end
      if (state == OUT && out_ready && !last_px) begin
        c <= last_c ? '0 : c + 1'b1;
        r <= last_c ? r + 1'b1 : r;
        t <= '0;
        acc <= '0;
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_scheduler.sv
// tb_conv_mac_scheduler: directed bench with buffer, multiplier and adder responders around conv_mac_scheduler
module tb_conv_mac_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b1;
  logic busy, done, rd_en, mul_valid, add_valid, out_valid;
  logic mul_res_valid = 1'b0, add_res_valid = 1'b0;
  logic [4:0] img_addr;
  logic [3:0] ker_addr;
  logic [1:0] out_row, out_col;
  logic [31:0] img_rdata = '0, ker_rdata = '0, mul_res = '0, add_res = '0;
  logic [31:0] mul_a, mul_b, add_a, add_b, out_data;
  logic [31:0] img [25];
  logic [31:0] ker [9];
  int tests = 0, fails = 0, cyc = 0;
  logic clr = 1'b0, inj = 1'b0, rnd = 1'b0;

  conv_mac_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .img_addr(img_addr), .ker_addr(ker_addr),
    .img_rdata(img_rdata), .ker_rdata(ker_rdata),
    .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
    .mul_res_valid(mul_res_valid), .mul_res(mul_res),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_res_valid(add_res_valid), .add_res(add_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] b);
    logic [10:0] e;
    e = {3'b0, b[30:23]} + 11'd896;
    return b[30:0] == 0 ? 0.0 : $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    d = $realtobits(x);
    return d[62:0] == 0 ? {d[63], 31'd0} : {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  // synchronous-read image/kernel buffers
  always @(posedge clk)
    if (rd_en) begin
      img_rdata <= img[img_addr];
      ker_rdata <= ker[ker_addr];
    end

  // pipelined FP units with fixed or random latency; inj adds junk results during FETCH
  int mcnt = 0, acnt = 0;
  logic [31:0] mres = '0, ares = '0;
  always @(negedge clk) begin
    mul_res_valid <= mcnt == 1 || (inj && rd_en);
    mul_res <= mcnt == 1 ? mres : 32'hDEADBEEF;
    add_res_valid <= acnt == 1 || (inj && rd_en);
    add_res <= acnt == 1 ? ares : 32'hBAADF00D;
    if (mcnt > 0) mcnt <= mcnt - 1;
    if (acnt > 0) acnt <= acnt - 1;
    if (mul_valid) begin
      mcnt <= rnd ? int'($urandom_range(7, 1)) : 1;
      mres <= r2f(f2r(mul_a) * f2r(mul_b));
    end
    if (add_valid) begin
      acnt <= rnd ? int'($urandom_range(7, 1)) : 1;
      ares <= r2f(f2r(add_a) + f2r(add_b));
    end
  end

  int hs_n, rd_n, mv_n, av_n, done_n, first_ov, last_hs, done_cyc, op_err;
  logic [31:0] hs_d [16];
  logic [3:0] hs_rc [16];
  logic [4:0] ia_log [128];
  logic [3:0] ka_log [128];
  always @(negedge clk)
    if (clr) begin
      hs_n <= 0; rd_n <= 0; mv_n <= 0; av_n <= 0; done_n <= 0; op_err <= 0; first_ov <= -1;
    end else begin
      if (rd_en && rd_n < 128) begin
        ia_log[rd_n] <= img_addr;
        ka_log[rd_n] <= ker_addr;
        rd_n <= rd_n + 1;
      end
      if (mul_valid) begin
        mv_n <= mv_n + 1;
        if (rd_n == 0 || mul_a !== ker[ka_log[rd_n-1]] || mul_b !== img[ia_log[rd_n-1]]) op_err <= op_err + 1;
      end
      if (add_valid) av_n <= av_n + 1;
      if (out_valid && first_ov < 0) first_ov <= cyc;
      if (out_valid && out_ready && hs_n < 16) begin
        hs_d[hs_n] <= out_data;
        hs_rc[hs_n] <= {out_row, out_col};
        hs_n <= hs_n + 1;
        last_hs <= cyc;
      end
      if (done) begin
        done_n <= done_n + 1;
        done_cyc <= cyc;
      end
    end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int kind);
    for (int i = 0; i < 25; i++) img[i] = kind == 2 ? r2f(real'(i)) : 32'h3F800000;
    for (int i = 0; i < 9; i++)
      ker[i] = kind == 1 ? 32'hBF800000 : (kind == 2 ? (i == 4 ? 32'h3F800000 : 32'h0) : 32'h3F800000);
  endtask

  task automatic start_run(output int s);
    clr = 1'b1;
    start = 1'b1;
    s = cyc;
    tick();
    clr = 1'b0;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_n == 0 && n < 4000) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_single_done"}, done_n, 1);
    check({tag, "_idle_after_done"}, busy, 0);
  endtask

  task automatic check_px(input string tag, input int kind);
    logic [31:0] e;
    check({tag, "_px_count"}, hs_n, 9);
    for (int p = 0; p < 9; p++) begin
      e = kind == 0 ? 32'h41100000 : (kind == 1 ? 32'h0 : r2f(real'((p / 3 + 1) * 5 + p % 3 + 1)));
      check($sformatf("%s_px%0d_data", tag, p), hs_d[p], e);
      check($sformatf("%s_px%0d_rowcol", tag, p), hs_rc[p], {2'(p / 3), 2'(p % 3)});
    end
    check({tag, "_mul_pulses"}, mv_n, 81);
    check({tag, "_add_pulses"}, av_n, 81);
    check({tag, "_operand_order"}, op_err, 0);
  endtask

  initial begin
    int s, n;
    logic [31:0] d0;
    logic [3:0] rc0;
    logic stable, act;
    load(0);
    tick();
    tick();
    check("rst_ctl", {busy, done, rd_en, mul_valid, add_valid, out_valid}, 0);
    check("rst_addr", {img_addr, ker_addr}, 0);
    check("rst_ops", mul_a | mul_b | add_a | add_b, 0);
    check("rst_out", {out_data, out_row, out_col}, 0);
    rst_n = 1'b1;
    tick();

    // ones * ones, unit latency, free-running downstream
    start_run(s);
    wait_done("ones");
    check_px("ones", 0);
    check("first_out_latency", first_ov - s, 46);
    check("done_after_last_hs", done_cyc - last_hs, 1);
    check("start_to_done", done_cyc - s, 415);
    check("fetch_count", rd_n, 81);
    for (int i = 0; i < 81; i++)
      check($sformatf("addr_%0d", i), {ia_log[i], ka_log[i]},
            {5'((i / 27 + i % 9 / 3) * 5 + i / 9 % 3 + i % 3), 4'(i % 9)});
    check("img_addr_p12_t4", ia_log[49], 13);
    check("ker_addr_p12_t4", ka_log[49], 4);

    // negative kernel clipped by ReLU; start held only in the done cycle must not restart
    load(1);
    start_run(s);
    n = 0;
    while (cyc < s + 415 && n < 1000) begin
      tick();
      n++;
    end
    check("done_pulse_cycle", done, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    check("neg_single_done", done_n, 1);
    check_px("neg", 1);

    // centre-tap kernel over a ramp, with a 20-cycle stall at pixel (0,1)
    load(2);
    out_ready = 1'b0;
    start_run(s);
    n = 0;
    while (!out_valid && n < 1000) begin
      tick();
      n++;
    end
    check("stall_first_pixel", {out_valid, out_row, out_col}, {1'b1, 4'd0});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 1000) begin
      tick();
      n++;
    end
    check("stall_pixel_rowcol", {out_valid, out_row, out_col}, {1'b1, 2'd0, 2'd1});
    check("stall_pixel_data", out_data, 32'h40E00000);
    d0 = out_data;
    rc0 = {out_row, out_col};
    stable = 1'b1;
    act = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== d0 || {out_row, out_col} !== rc0) stable = 1'b0;
      if (rd_en || mul_valid) act = 1'b1;
    end
    check("stall_outputs_stable", stable, 1);
    check("stall_no_activity", act, 0);
    out_ready = 1'b1;
    tick();
    check("stall_released", {out_valid, rd_en}, {1'b0, 1'b1});
    check("stall_hs_count", hs_n, 2);
    wait_done("ramp");
    check_px("ramp", 2);
    check("ramp_px12_is_13", hs_d[5], 32'h41500000);

    // random latencies, junk results during FETCH and start pulses while busy
    load(0);
    inj = 1'b1;
    rnd = 1'b1;
    start_run(s);
    repeat (3) begin
      repeat (150) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_done("rand");
    check_px("rand", 0);
    inj = 1'b0;
    rnd = 1'b0;

    // reset pulse during tap 5 of pixel (1,1), then a clean run
    start_run(s);
    n = 0;
    while (!(hs_n == 4 && rd_en && ker_addr == 4'd5) && n < 2000) begin
      tick();
      n++;
    end
    check("reach_p11_t5", {hs_n == 4, rd_en, ker_addr}, {2'b11, 4'd5});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ctl", {busy, done, rd_en, mul_valid, add_valid, out_valid}, 0);
    check("abort_buses", {img_addr, ker_addr, out_data, out_row, out_col}, 0);
    check("abort_ops", mul_a | mul_b | add_a | add_b, 0);
    repeat (20) tick();
    check("abort_no_pixel", hs_n, 4);
    check("abort_no_done", done_n, 0);
    check("abort_stays_idle", busy, 0);
    start_run(s);
    wait_done("restart");
    check_px("restart", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
